// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank
// Brief    : Multi-channel alarm controller with per-channel ring/snooze
//            state, minute-boundary matching and a flashing LED bank.
// Revision : 1.0
// ============================================================================
module alarm_bank #(
    parameter int NUM_ALARMS  = 4,
    parameter int LED_WIDTH   = 16,
    parameter int SNOOZE_MINS = 5,
    parameter int RING_MINS   = 10,
    parameter int FLASH_DIV   = 50_000_000
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          minute_tick,
    input  logic [4:0]                    cur_hours,
    input  logic [5:0]                    cur_mins,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_ALARMS)-1:0] wr_sel,
    input  logic [4:0]                    wr_hours,
    input  logic [5:0]                    wr_mins,
    input  logic                          wr_arm,
    input  logic                          snooze,
    input  logic                          dismiss,
    output logic [NUM_ALARMS-1:0]         ringing,
    output logic [$clog2(NUM_ALARMS)-1:0] active_sel,
    output logic [LED_WIDTH-1:0]          led
);

    localparam int c_SEL_W  = $clog2(NUM_ALARMS);
    localparam int c_FCNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_RINGING = 2'd2;
    localparam logic [1:0] c_SNOOZED = 2'd3;

    localparam logic [5:0]          c_SNOOZE_CNT = 6'(SNOOZE_MINS);
    localparam logic [5:0]          c_RING_CNT   = 6'(RING_MINS);
    localparam logic [c_FCNT_W-1:0] c_FLASH_LAST = c_FCNT_W'(FLASH_DIV - 1);

    logic                  w_wr_valid;
    logic [NUM_ALARMS-1:0] w_ring_nx;
    logic [c_SEL_W-1:0]    w_sel_nx;
    logic [c_FCNT_W-1:0]   r_fcnt;
    logic [c_FCNT_W-1:0]   w_fcnt_nx;
    logic                  r_phase;
    logic                  w_phase_nx;
    logic [NUM_ALARMS-1:0] r_ringing;
    logic [c_SEL_W-1:0]    r_active_sel;
    logic [LED_WIDTH-1:0]  r_led;

    // An out-of-range time makes the write a no-op, so lower events still act.
    assign w_wr_valid = (wr_hours <= 5'd23) && (wr_mins <= 6'd59);

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
        logic [1:0] r_state;
        logic [1:0] w_state_nx;
        logic [4:0] r_hours;
        logic [4:0] w_hours_nx;
        logic [5:0] r_mins;
        logic [5:0] w_mins_nx;
        logic [5:0] r_mcnt;
        logic [5:0] w_mcnt_nx;
        logic       w_wr_hit;

        assign w_wr_hit = wr_en && (wr_sel == c_SEL_W'(gi)) && w_wr_valid;

        always_comb begin
            w_state_nx = r_state;
            w_hours_nx = r_hours;
            w_mins_nx  = r_mins;
            w_mcnt_nx  = r_mcnt;
            if (w_wr_hit) begin
                if (wr_arm) begin
                    w_state_nx = c_ARMED;
                    w_hours_nx = wr_hours;
                    w_mins_nx  = wr_mins;
                    w_mcnt_nx  = 6'd0;
                end else begin
                    w_state_nx = c_IDLE;
                end
            end else if (dismiss && (r_state == c_RINGING || r_state == c_SNOOZED)) begin
                w_state_nx = c_ARMED;
            end else if (snooze && r_state == c_RINGING) begin
                w_state_nx = c_SNOOZED;
                w_mcnt_nx  = c_SNOOZE_CNT;
            end else if (minute_tick) begin
                case (r_state)
                    c_ARMED: begin
                        if (cur_hours == r_hours && cur_mins == r_mins) begin
                            w_state_nx = c_RINGING;
                            w_mcnt_nx  = 6'd0;
                        end
                    end
                    c_RINGING: begin
                        w_mcnt_nx = r_mcnt + 6'd1;
                        if (r_mcnt + 6'd1 == c_RING_CNT) begin
                            w_state_nx = c_ARMED;
                        end
                    end
                    c_SNOOZED: begin
                        w_mcnt_nx = r_mcnt - 6'd1;
                        if (r_mcnt - 6'd1 == 6'd0) begin
                            w_state_nx = c_RINGING;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                r_state <= c_IDLE;
                r_hours <= 5'd0;
                r_mins  <= 6'd0;
                r_mcnt  <= 6'd0;
            end else begin
                r_state <= w_state_nx;
                r_hours <= w_hours_nx;
                r_mins  <= w_mins_nx;
                r_mcnt  <= w_mcnt_nx;
            end
        end

        assign w_ring_nx[gi] = (w_state_nx == c_RINGING);
    end

    always_comb begin
        w_sel_nx = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (w_ring_nx[k]) begin
                w_sel_nx = c_SEL_W'(k);
            end
        end
    end

    assign w_fcnt_nx  = (r_fcnt == c_FLASH_LAST) ? '0 : r_fcnt + 1'b1;
    assign w_phase_nx = (r_fcnt == c_FLASH_LAST) ? ~r_phase : r_phase;

    // Outputs are registered from next-state values so they line up with the channel state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
            r_ringing    <= '0;
            r_active_sel <= '0;
            r_led        <= '0;
        end else begin
            r_fcnt       <= w_fcnt_nx;
            r_phase      <= w_phase_nx;
            r_ringing    <= w_ring_nx;
            r_active_sel <= w_sel_nx;
            r_led        <= {LED_WIDTH{w_phase_nx & (|w_ring_nx)}};
        end
    end

    assign ringing    = r_ringing;
    assign active_sel = r_active_sel;
    assign led        = r_led;

endmodule
`default_nettype wire

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel alarm controller that replaces the single combinational alarm compare in the clock top level. It holds `NUM_ALARMS` independently armed alarm times and compares them against the running time from `count_time` on each minute boundary. Each channel has its own ring/snooze state machine with snooze and auto-timeout, and the block drives a flashing LED bank. Writes come from the set-alarm display mode; snooze and dismiss come from debounced buttons.

## Interface
Parameters:
- `NUM_ALARMS`, 4: number of alarm channels; legal range 2..16.
- `LED_WIDTH`, 16: width of the `led` output.
- `SNOOZE_MINS`, 5: snooze length in minutes; legal range 1..63.
- `RING_MINS`, 10: minutes a channel rings before it stops itself; legal range 1..63.
- `FLASH_DIV`, 50_000_000: `clk` cycles per LED phase (half-period); must be ≥ 1.

Ports:
- `clk`, in, 1: master clock. Everything is sampled on the rising edge.
- `clr`, in, 1: reset. Synchronous, active-high.
- `minute_tick`, in, 1: one-cycle pulse in the cycle where `cur_hours`/`cur_mins` first show the new minute.
- `cur_hours`, in, 5: current hour, binary 0..23.
- `cur_mins`, in, 6: current minute, binary 0..59.
- `wr_en`, in, 1: single-cycle write strobe.
- `wr_sel`, in, $clog2(NUM_ALARMS): channel selected for the write.
- `wr_hours`, in, 5: alarm hour to write.
- `wr_mins`, in, 6: alarm minute to write.
- `wr_arm`, in, 1: 1 = store the time and arm the channel; 0 = disarm the channel.
- `snooze`, in, 1: debounced one-cycle pulse.
- `dismiss`, in, 1: debounced one-cycle pulse.
- `ringing`, out, NUM_ALARMS: per-channel flag; bit i is high while channel i is in RINGING.
- `active_sel`, out, $clog2(NUM_ALARMS): lowest-indexed channel in RINGING; 0 when no channel is ringing.
- `led`, out, LED_WIDTH: flash output.

## Operation
Per-channel states:
- IDLE: disarmed.
- ARMED: waiting for a time match.
- RINGING: alarm active.
- SNOOZED: alarm paused.

Each channel holds a stored time (hours, minutes) and a 6-bit minute counter `mcnt`.

Per-channel priority, highest first:
- `clr`
- write
- dismiss
- snooze
- `minute_tick`

Only the highest-priority applicable event acts on a channel in a given cycle.

Events:
- Write: applies when `wr_en` is high and `wr_sel` equals the channel index.
  - If `wr_hours` > 23 or `wr_mins` > 59, the whole write is ignored and no state changes.
  - If `wr_arm`=1: store the time, go to ARMED, and clear `mcnt`. This applies from any state and cancels ringing or snooze.
  - If `wr_arm`=0: go to IDLE. The stored time is kept.
  - If `wr_sel` ≥ NUM_ALARMS, the write is ignored.
- Dismiss: acts only on channels in RINGING or SNOOZED. They go to ARMED, so they ring again the next day. Channels in other states are unaffected and may still take a lower-priority event in the same cycle.
- Snooze: acts only on channels in RINGING. They go to SNOOZED with `mcnt`=SNOOZE_MINS. Snooze has no effect in SNOOZED; the snooze countdown is not restarted.
- `minute_tick`:
  - ARMED: if `cur_hours`==stored hours and `cur_mins`==stored minutes, go to RINGING with `mcnt`=0.
  - RINGING: `mcnt`+1. When the incremented value equals RING_MINS, go to ARMED (missed alarm).
  - SNOOZED: `mcnt`−1. When it reaches 0, go to RINGING with `mcnt`=0.
  - IDLE: no change.
- Snooze and dismiss are global. They apply to every eligible channel at once.
- The block never triggers on a match without `minute_tick`. Setting the clock onto an alarm time mid-minute does not ring.

Flash:
- A free-running counter counts 0..FLASH_DIV−1 and toggles `phase` on wrap.
- `led` = all ones when `phase`=1 and any channel is in RINGING; otherwise all zeros.
- SNOOZED alone does not flash.

## Timing
- All outputs are registered.
- A state change caused by an event in cycle N is visible on `ringing`/`active_sel` at cycle N+1.
- `led` reflects the ringing state and `phase` registered at N+1; it becomes non-zero no later than the first `phase`=1 cycle after that.
- Values after `clr`:
  - All channels IDLE, stored times 00:00, `mcnt`=0.
  - Flash counter 0, `phase`=0.
  - `ringing`=0, `active_sel`=0, `led`=0.
- `clr` mid-ring or mid-snooze discards everything. No alarm state survives reset.
- A channel armed by a write in cycle N whose time matches a `minute_tick` in the same cycle N does not ring; the write takes priority.

## Test plan
- Alarm match: after `clr`, write ch1 = 07:30, armed. Pulse `minute_tick` with cur = 07:29 → no ring. Pulse it with cur = 07:30 → `ringing`=0b0010 and `active_sel`=1 one cycle later. With FLASH_DIV=4, `led` toggles between 0xFFFF and 0 every 4 cycles.
- Snooze: ch1 ringing, SNOOZE_MINS=5. Pulse `snooze` → `ringing`=0 and `led`=0. After 4 `minute_tick`s ch1 is still off; after the 5th, `ringing`=0b0010.
- Auto-timeout, multiple channels, and dismiss: RING_MINS=3; ch0 and ch2 both set to 12:00 and triggered together → `ringing`=0b0101, `active_sel`=0. After 3 ticks both return to ARMED and `ringing`=0. Trigger both again, then pulse `dismiss` → `ringing`=0. The following day's 12:00 tick rings both again.
- Invalid and disarm writes: write ch3 = 24:10 → ignored, ch3 stays IDLE. Write ch3 = 23:60 → ignored. Write ch2 with `wr_arm`=0 while ringing → ch2 goes IDLE, and a later 12:00 tick does not ring it.
- Simultaneous events: ch0 ringing and ch1 ARMED matching. `dismiss` and the matching `minute_tick` in the same cycle → ch0 goes to ARMED and ch1 goes to RINGING (`ringing`=0b0010). Assert `snooze` and `dismiss` together on a ringing channel → ARMED.
- Reset mid-ring: assert `clr` while ch0 is ringing → next cycle all outputs are 0. A subsequent matching tick does not ring, because the channel was reset to IDLE.
